// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one combinational AES-128 core between two requesters.
// Optional performance counters are enabled with `define AES_ARB_PERF_EN.
module aes_core_arbiter #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_plaintext,
    input  logic [127:0] req0_key,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_plaintext,
    input  logic [127:0] req1_key,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_ciphertext,
    output logic         rsp_id,
    output logic [127:0] core_plaintext,
    output logic [127:0] core_key,
    input  logic [127:0] core_ciphertext,
    output logic         busy
`ifdef AES_ARB_PERF_EN
    ,
    output logic [15:0]  perf_done0,
    output logic [15:0]  perf_done1,
    output logic [15:0]  perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic       prio;
    logic       id_q;
    logic       accept;
    logic       grant_id;

    // prio names the requester that wins a tie; it flips away from each granted requester.
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        grant_id   = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || !prio)) begin
                    req0_ready = 1'b1;
                    accept     = 1'b1;
                    grant_id   = 1'b0;
                    state_next = SETTLE;
                end else if (req1_valid) begin
                    req1_ready = 1'b1;
                    accept     = 1'b1;
                    grant_id   = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == 8'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            prio           <= 1'b0;
            id_q           <= 1'b0;
            core_plaintext <= '0;
            core_key       <= '0;
            rsp_ciphertext <= '0;
            rsp_id         <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                core_plaintext <= grant_id ? req1_plaintext : req0_plaintext;
                core_key       <= grant_id ? req1_key : req0_key;
                id_q           <= grant_id;
                prio           <= ~grant_id;
                cnt            <= CNT_LOAD;
            end
            // The core output is only trusted once the inputs have been stable for the full window.
            if (state == SETTLE) begin
                if (cnt != 8'd0) begin
                    cnt <= cnt - 8'd1;
                end else begin
                    rsp_ciphertext <= core_ciphertext;
                    rsp_id         <= id_q;
                end
            end
        end
    end

`ifdef AES_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_done0 <= 16'd0;
            perf_done1 <= 16'd0;
            perf_stall <= 16'd0;
        end else if (state == RESP) begin
            if (rsp_ready) begin
                if (rsp_id) begin
                    perf_done1 <= perf_done1 + 16'd1;
                end else begin
                    perf_done0 <= perf_done0 + 16'd1;
                end
            end else if (perf_stall != 16'hFFFF) begin
                perf_stall <= perf_stall + 16'd1;
            end
        end
    end
`endif

endmodule
